dut_seq_ctrl: RTL and testbench
===============================

Name: dut_seq_ctrl

Overview:
- Synthesizable run controller for the 3-input/3-output `dut` block.
- Applies static settings `param_a`/`param_b`/`param_c` and holds the dut in reset for a fixed number of cycles.
- Plays a loadable program of `sig` vectors and checks `{x,y,z}` against per-vector expected values, counting mismatches.
- Sits between a host or configuration interface and the dut; replaces open-coded reset and stimulus sequencing.

Parameters:
- DEPTH, 16: program memory entries (power of 2). AW = $clog2(DEPTH).
- RST_CYCLES, 10: cycles `dut_rst_n` is held low after start (≥1).
- DUT_LAT, 1: edges from a `dut_sig` update to the matching `{x,y,z}` sample (≥1).
- CNT_W, 8: error counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request, sampled in IDLE only.
- cfg_params  in  3  {a,b,c} settings, captured on start.
- num_vec  in  AW+1  vectors to run, 0..DEPTH; captured on start.
- prog_we  in  1  program write enable; ignored while busy.
- prog_addr  in  AW  program write address.
- prog_sig  in  3  stimulus for the entry.
- prog_exp  in  3  expected {x,y,z} for the entry.
- busy  out  1  high from the edge after start until the done edge.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  err_cnt==0 at done; held until next start.
- err_cnt  out  CNT_W  mismatches in current/last run, saturating.
- dut_rst_n  out  1  dut reset, active-low.
- dut_param_a, dut_param_b, dut_param_c  out  1 each  dut settings.
- dut_sig  out  [0:2]  dut stimulus.
- dut_x, dut_y, dut_z  in  1 each  dut outputs.

Behaviour:
- Reset (async): state IDLE; `busy`, `done`, `pass`, `err_cnt`, `dut_rst_n`, `dut_param_*`, `dut_sig` all 0. Program memory is not reset.
- Reset asserted mid-run: abort to IDLE with the reset values above; no `done`.
- All outputs are registered.
- States: IDLE, RESET, RUN, DRAIN, DONE.
- IDLE, start=1 (edge 0):
  - `dut_param_*` <= `cfg_params`; latch `num_vec`.
  - Clear `err_cnt` and `pass`; `busy` <= 1; `dut_rst_n` <= 0.
  - Next state RESET.
- RESET:
  - Counts RST_CYCLES edges (1..RST_CYCLES).
  - On edge RST_CYCLES: `dut_rst_n` <= 1; next state RUN, or DRAIN if `num_vec`==0.
- RUN:
  - Each edge: `dut_sig` <= mem[idx].sig; mem[idx].exp enters a DUT_LAT-deep valid/exp pipe; idx++.
  - On the edge driving vector `num_vec`-1: next state DRAIN.
  - The following edge sets `dut_sig` <= 0.
- Compare:
  - The vector driven at edge E is compared at edge E+DUT_LAT.
  - `{dut_x,dut_y,dut_z}` !== exp increments `err_cnt`; any X/Z bit counts as a mismatch.
  - `err_cnt` saturates at 2^CNT_W−1.
- DRAIN: waits until the pipe is empty (DUT_LAT edges), then DONE.
- DONE edge: `done` <= 1 for exactly one cycle; `busy` <= 0; `pass` <= (`err_cnt`==0, including a final-edge compare); next state IDLE.
- Timing: `done` rises on edge RST_CYCLES+`num_vec`+DUT_LAT after the start edge.
- After a run, `dut_rst_n`=1 and `dut_param_*` hold until the next start or reset.
- `start` while busy: ignored.
- `prog_we` while busy: ignored.
- `num_vec` > DEPTH: clamped to DEPTH.
- Index wrap: idx does not wrap; the run ends at `num_vec`.

Decomposition:
- Package `dut_seq_pkg`:
  - `state_e` enum (IDLE, RESET, RUN, DRAIN, DONE).
  - `vec_t` struct {sig[0:2], exp[2:0]}.
  - Localparam for the default RST_CYCLES.
- Sub-module `dut_seq_cmp`: DUT_LAT-deep exp/valid shift pipe plus saturating mismatch counter. Inputs: push, exp, xyz, clear. Outputs: err_cnt, empty.

Test Plan:
- Load sig 111,011,001,000 with exp matching a registered reference model; start, `num_vec`=4, `cfg_params`=110 → `dut_param`=1,1,0; `dut_rst_n` low 10 cycles; `done` at edge 15; `err_cnt`=0; `pass`=1.
- Same program with entry 2 exp corrupted to 111 → `err_cnt`=1, `pass`=0, `done` still at edge 15.
- `num_vec`=0 → `dut_sig` stays 000; `done` at edge 11; `pass`=1.
- `rst` asserted during RUN, vector 2 → all outputs 0 immediately; later start with `num_vec`=4 → clean run, `err_cnt`=0.
- `start` and `prog_we` pulsed while busy → no restart; memory unchanged (read back via a second run, `err_cnt`=0).
- CNT_W=2, 16 vectors all mismatching (dut_x forced to X) → `err_cnt`=3 (saturated), `pass`=0.

Source files
------------

// File: rtl/dut_seq_pkg.sv
// Shared types for the dut run controller: FSM states, program entry layout
// and the default dut reset length. No pipeline latency; no flow control.
package dut_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [0:2] sig;
        logic [2:0] exp;
    } vec_t;

    localparam int RST_CYCLES_DEF = 10;

endpackage

// File: rtl/dut_seq_cmp.sv
// Expected-value delay line and saturating mismatch counter; compares DUT_LAT
// edges after push. No backpressure: every pushed entry is compared exactly once.
module dut_seq_cmp #(
    parameter int DUT_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [2:0]       exp,
    input  logic [2:0]       xyz,
    output logic [CNT_W-1:0] err_cnt,
    output logic             miss,
    output logic             empty
);

    logic [DUT_LAT-1:0] vld;
    logic [2:0]         exp_pipe [DUT_LAT];

    // Case inequality so that any X/Z bit from the dut is scored as a mismatch.
    assign miss = vld[DUT_LAT-1] && (xyz !== exp_pipe[DUT_LAT-1]);

    // Empty once the only entry left (if any) is the one compared this edge.
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DUT_LAT - 1; i++) begin
            if (vld[i]) begin
                empty = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld     <= '0;
            err_cnt <= '0;
            for (int i = 0; i < DUT_LAT; i++) begin
                exp_pipe[i] <= '0;
            end
        end else if (clear) begin
            vld     <= '0;
            err_cnt <= '0;
        end else begin
            vld[0]      <= push;
            exp_pipe[0] <= exp;
            for (int i = 1; i < DUT_LAT; i++) begin
                vld[i]      <= vld[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
            end
            if (miss && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dut_seq_ctrl.sv
// Run controller for the 3-in/3-out dut: static params, timed dut reset, then a
// program of sig vectors with per-vector expected outputs. done after RST_CYCLES+num_vec+DUT_LAT edges.
module dut_seq_ctrl
    import dut_seq_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = RST_CYCLES_DEF,
    parameter int DUT_LAT    = 1,
    parameter int CNT_W      = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       cfg_params,
    input  logic [AW:0]      num_vec,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [0:2]       prog_sig,
    input  logic [2:0]       prog_exp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             dut_rst_n,
    output logic             dut_param_a,
    output logic             dut_param_b,
    output logic             dut_param_c,
    output logic [0:2]       dut_sig,
    input  logic             dut_x,
    input  logic             dut_y,
    input  logic             dut_z
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int DW = $clog2(DUT_LAT + 1);

    state_e        state;
    logic [RW-1:0] rst_cnt;
    logic [DW-1:0] drain_cnt;
    logic [AW-1:0] idx;
    logic [AW:0]   nv_q;
    logic [AW:0]   nv_clamped;
    vec_t          mem [DEPTH];
    vec_t          cur;
    logic          last_vec;
    logic          push;
    logic          clear;
    logic          miss;
    logic          pipe_empty;

    assign cur      = mem[idx];
    assign push     = (state == S_RUN);
    assign clear    = (state == S_IDLE) && start;
    assign last_vec = ({1'b0, idx} == (nv_q - 1'b1));

    always_comb begin
        nv_clamped = num_vec;
        if (num_vec > (AW+1)'(DEPTH)) begin
            nv_clamped = (AW+1)'(DEPTH);
        end
    end

    // Program memory is deliberately left unreset and frozen while a run is active.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            mem[prog_addr].sig <= prog_sig;
            mem[prog_addr].exp <= prog_exp;
        end
    end

    dut_seq_cmp #(
        .DUT_LAT (DUT_LAT),
        .CNT_W   (CNT_W)
    ) u_cmp (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .push    (push),
        .exp     (cur.exp),
        .xyz     ({dut_x, dut_y, dut_z}),
        .err_cnt (err_cnt),
        .miss    (miss),
        .empty   (pipe_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            dut_rst_n   <= 1'b0;
            dut_param_a <= 1'b0;
            dut_param_b <= 1'b0;
            dut_param_c <= 1'b0;
            dut_sig     <= '0;
            rst_cnt     <= '0;
            drain_cnt   <= '0;
            idx         <= '0;
            nv_q        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dut_param_a <= cfg_params[2];
                        dut_param_b <= cfg_params[1];
                        dut_param_c <= cfg_params[0];
                        nv_q        <= nv_clamped;
                        pass        <= 1'b0;
                        busy        <= 1'b1;
                        dut_rst_n   <= 1'b0;
                        rst_cnt     <= '0;
                        drain_cnt   <= '0;
                        idx         <= '0;
                        state       <= S_RESET;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        dut_rst_n <= 1'b1;
                        state     <= (nv_q == '0) ? S_DRAIN : S_RUN;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    dut_sig <= cur.sig;
                    idx     <= idx + 1'b1;
                    if (last_vec) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    dut_sig <= '0;
                    // The last expected value is compared on this same edge, so pass must include miss.
                    if ((drain_cnt == DW'(DUT_LAT - 1)) && pipe_empty) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_cnt == '0) && !miss;
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dut_seq_ctrl.sv
// Bench for dut_seq_ctrl: table rows, hand-written corner sequences and random
// programs scored against a mismatch-count reference; a CNT_W=2 copy covers saturation.
module tb_dut_seq_ctrl;

    localparam int DEPTH = 16;
    localparam int RST   = 10;
    localparam int LAT   = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] cfg_params;
    logic [4:0] num_vec;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [0:2] prog_sig;
    logic [2:0] prog_exp;

    logic       busy, done, pass, dut_rst_n, pa, pb, pc;
    logic [7:0] err_cnt;
    logic [0:2] dut_sig;
    logic       dx, dy, dz;

    logic       busy2, done2, pass2, rstn2, pa2, pb2, pc2;
    logic [1:0] err2;
    logic [0:2] sig2;
    logic       x2, y2, z2;
    logic       inv2;

    int checks = 0;
    int errors = 0;
    logic [0:2] m_sig [DEPTH];
    logic [2:0] m_exp [DEPTH];
    logic [1:0] err2_at_done;
    logic       pass2_at_done;

    always #5 clk = ~clk;

    // Environment dut: combinational AND of each stimulus bit with its setting.
    always_comb begin
        {dx, dy, dz} = {dut_sig[0] & pa, dut_sig[1] & pb, dut_sig[2] & pc};
        {x2, y2, z2} = {sig2[0] & pa2, sig2[1] & pb2, sig2[2] & pc2} ^ {3{inv2}};
    end

    dut_seq_ctrl #(.DEPTH(DEPTH), .RST_CYCLES(RST), .DUT_LAT(LAT), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .cfg_params(cfg_params), .num_vec(num_vec),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_sig(prog_sig), .prog_exp(prog_exp),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .dut_rst_n(dut_rst_n),
        .dut_param_a(pa), .dut_param_b(pb), .dut_param_c(pc), .dut_sig(dut_sig),
        .dut_x(dx), .dut_y(dy), .dut_z(dz)
    );

    dut_seq_ctrl #(.DEPTH(DEPTH), .RST_CYCLES(RST), .DUT_LAT(LAT), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start), .cfg_params(cfg_params), .num_vec(num_vec),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_sig(prog_sig), .prog_exp(prog_exp),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .dut_rst_n(rstn2),
        .dut_param_a(pa2), .dut_param_b(pb2), .dut_param_c(pc2), .dut_sig(sig2),
        .dut_x(x2), .dut_y(y2), .dut_z(z2)
    );

    function automatic logic [2:0] ref_out(input logic [0:2] s, input logic [2:0] p);
        return {s[0] & p[2], s[1] & p[1], s[2] & p[0]};
    endfunction

    function automatic int ref_err(input int nv, input logic [2:0] p);
        int n = (nv > DEPTH) ? DEPTH : nv;
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (m_exp[i] != ref_out(m_sig[i], p)) cnt++;
        end
        return (cnt > 255) ? 255 : cnt;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic load(input int a, input logic [0:2] s, input logic [2:0] e);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = 4'(a);
        prog_sig  = s;
        prog_exp  = e;
        @(negedge clk);
        prog_we   = 1'b0;
        m_sig[a]  = s;
        m_exp[a]  = e;
    endtask

    task automatic run_check(input string tag, input int nv, input logic [2:0] p, input bit inject,
                             input int e_err, input bit e_pass, input int e_done);
        int n = (nv > DEPTH) ? DEPTH : nv;
        int rst_rise = -1;
        int done_edge = -1;
        int err_o = -1;
        bit pass_o = 1'b0;
        bit seq_bad = 1'b0;
        bit busy_bad = 1'b0;
        bit clr_bad = 1'b0;
        logic [0:2] e_sig;
        @(negedge clk);
        start      = 1'b1;
        num_vec    = 5'(nv);
        cfg_params = p;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 100 && done_edge < 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 && (err_cnt != 0 || pass != 0)) clr_bad = 1'b1;
            if (rst_rise < 0 && dut_rst_n) rst_rise = k;
            e_sig = (k > RST && k <= RST + n) ? m_sig[k-RST-1] : 3'b000;
            if (dut_sig !== e_sig) seq_bad = 1'b1;
            if (done) begin
                done_edge     = k;
                err_o         = int'(err_cnt);
                pass_o        = pass;
                err2_at_done  = err2;
                pass2_at_done = pass2;
                if (busy) busy_bad = 1'b1;
            end else if (!busy) begin
                busy_bad = 1'b1;
            end
            if (inject && k == 5) begin
                start     = 1'b1;
                prog_we   = 1'b1;
                prog_addr = 4'd0;
                prog_sig  = 3'b000;
                prog_exp  = 3'b111;
            end
            if (inject && k == 6) begin
                start   = 1'b0;
                prog_we = 1'b0;
            end
        end
        chk({tag, "_done_edge"}, done_edge, e_done);
        chk({tag, "_err_cnt"}, err_o, e_err);
        chk({tag, "_pass"}, pass_o, e_pass);
        chk({tag, "_rst_n_rise"}, rst_rise, RST);
        chk({tag, "_params"}, {pa, pb, pc}, p);
        chk({tag, "_sig_seq_bad"}, seq_bad, 0);
        chk({tag, "_busy_bad"}, busy_bad, 0);
        chk({tag, "_clear_bad"}, clr_bad, 0);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    typedef struct {
        int         nv;
        logic [2:0] p;
        bit         corrupt;
        int         e_err;
        bit         e_pass;
        int         e_done;
    } row_t;

    row_t tbl [5];

    initial begin
        logic [0:2] s;
        logic [2:0] p;
        logic [2:0] e;
        int nv, ee;
        tbl[0] = '{nv: 4,  p: 3'b110, corrupt: 0, e_err: 0, e_pass: 1, e_done: 15};
        tbl[1] = '{nv: 4,  p: 3'b110, corrupt: 1, e_err: 1, e_pass: 0, e_done: 15};
        tbl[2] = '{nv: 0,  p: 3'b110, corrupt: 0, e_err: 0, e_pass: 1, e_done: 11};
        tbl[3] = '{nv: 4,  p: 3'b111, corrupt: 0, e_err: 3, e_pass: 0, e_done: 15};
        tbl[4] = '{nv: 20, p: 3'b110, corrupt: 0, e_err: 0, e_pass: 1, e_done: 27};

        rst = 1'b1; start = 1'b0; cfg_params = '0; num_vec = '0;
        prog_we = 1'b0; prog_addr = '0; prog_sig = '0; prog_exp = '0; inv2 = 1'b0;
        #1;
        chk("reset_state", {busy, done, pass, err_cnt, dut_rst_n, pa, pb, pc, dut_sig}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        load(0, 3'b111, ref_out(3'b111, 3'b110));
        load(1, 3'b011, ref_out(3'b011, 3'b110));
        load(2, 3'b001, ref_out(3'b001, 3'b110));
        load(3, 3'b000, ref_out(3'b000, 3'b110));
        for (int i = 4; i < DEPTH; i++) begin
            s = 3'(i * 5);
            load(i, s, ref_out(s, 3'b110));
        end

        for (int r = 0; r < 5; r++) begin
            load(2, 3'b001, tbl[r].corrupt ? 3'b111 : ref_out(3'b001, 3'b110));
            run_check($sformatf("row%0d", r), tbl[r].nv, tbl[r].p, 1'b0,
                      tbl[r].e_err, tbl[r].e_pass, tbl[r].e_done);
        end

        // Reset during RUN, just after vector 2 has been driven.
        @(negedge clk);
        start = 1'b1; num_vec = 5'd4; cfg_params = 3'b110;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (RST + 3) @(posedge clk);
        #1;
        chk("midrun_sig", dut_sig, m_sig[2]);
        rst = 1'b1;
        #1;
        chk("abort_state", {busy, done, pass, err_cnt, dut_rst_n, pa, pb, pc, dut_sig}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_check("after_abort", 4, 3'b110, 1'b0, 0, 1'b1, 15);

        run_check("busy_inject", 4, 3'b110, 1'b1, 0, 1'b1, 15);
        run_check("readback", 4, 3'b110, 1'b0, 0, 1'b1, 15);

        inv2 = 1'b1;
        run_check("sat_main", 16, 3'b110, 1'b0, 0, 1'b1, 27);
        chk("sat_err_cnt", err2_at_done, 3);
        chk("sat_pass", pass2_at_done, 0);
        inv2 = 1'b0;

        for (int it = 0; it < 12; it++) begin
            p = 3'($urandom);
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    s = 3'($urandom);
                    e = ($urandom_range(0, 3) == 0) ? 3'($urandom) : ref_out(s, p);
                    load(i, s, e);
                end
            end
            nv = int'($urandom_range(0, 20));
            ee = ref_err(nv, p);
            run_check($sformatf("rand%0d", it), nv, p, 1'b0, ee, (ee == 0),
                      RST + ((nv > DEPTH) ? DEPTH : nv) + LAT);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
